lsu_mem_initiator: RTL and testbench

- Load/store initiator between the execute stage and the byte-lane data memory.
- Accepts one load or store per handshake and converts it into word-aligned memory transactions with byte strobes.
- For loads, extracts and sign- or zero-extends the addressed bytes.
- Runs a multi-cycle FSM against a memory with a grant/read-valid handshake and variable read latency.

---
 rtl/lsu_mem_initiator.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// ---------------------------------------------------------------------------
// lsu_mem_initiator
//   Load/store initiator between the execute stage and a byte-lane data
//   memory. Each accepted request becomes one word-aligned memory
//   transaction, or two when it straddles a word boundary. Each transaction
//   carries byte strobes and lane-shifted write data. Load data is gathered
//   into a 64-bit buffer, then shifted and sign- or zero-extended. A
//   watchdog aborts a load whose read data never arrives.
//
//   Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned halfword
//   and word accesses into two word transactions. Without it, such accesses
//   complete immediately with a fault and do not touch memory.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   i_req_valid/o_req_ready, i_req_is_store, i_req_funct3, i_req_addr,
//   i_req_wdata           request from the pipeline (ready only in IDLE)
//   o_resp_valid, o_resp_rdata, o_resp_fault
//                         one-cycle completion pulse with load data / fault
//   o_mem_req, i_mem_gnt, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata
//                         memory request channel (held until granted)
//   i_mem_rvalid, i_mem_rdata
//                         memory read return channel
// ---------------------------------------------------------------------------
module lsu_mem_initiator #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_is_store,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_resp_valid,
  output logic [XLEN-1:0] o_resp_rdata,
  output logic            o_resp_fault,
  output logic            o_mem_req,
  input  logic            i_mem_gnt,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_wstrb,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
  } state_t;

  state_t r_state, w_state_next;

  // Latched request fields
  logic            r_is_store;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [63:0]     r_buf;
  logic [CW-1:0]   r_wait_cnt;

  // Registered outputs
  logic            r_req_ready, r_resp_valid, r_resp_fault;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_mem_req, r_mem_we;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata;
  logic [3:0]      r_mem_wstrb;

  // In IDLE the decode must look at the incoming request (it is being
  // accepted this cycle); afterwards it looks at the latched copy.
  logic            w_idle;
  logic            w_is_store;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_addr, w_wdata;
  assign w_idle     = (r_state == S_IDLE);
  assign w_is_store = w_idle ? i_req_is_store : r_is_store;
  assign w_funct3   = w_idle ? i_req_funct3   : r_funct3;
  assign w_addr     = w_idle ? i_req_addr     : r_addr;
  assign w_wdata    = w_idle ? i_req_wdata    : r_wdata;

  logic [1:0]      w_off;
  logic [3:0]      w_base;
  logic [7:0]      w_s8;
  logic [63:0]     w_d64;
  logic            w_split, w_illegal, w_misalign_fault, w_timeout;
  logic [XLEN-1:0] w_word0, w_word1;

  assign w_off = w_addr[1:0];

  always_comb begin
    w_base = 4'b1111;
    case (w_funct3[1:0])
      2'b00:   w_base = 4'b0001;
      2'b01:   w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
  end

  assign w_s8    = {4'b0000, w_base} << w_off;
  assign w_d64   = {32'h0, w_wdata} << {w_off, 3'b000};
  assign w_split = |w_s8[7:4];
  assign w_word0 = {w_addr[XLEN-1:2], 2'b00};
  assign w_word1 = w_word0 + 32'd4;  // wraps modulo 2^32

  assign w_illegal = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11) ||
                     (w_is_store && w_funct3[2]);
  assign w_misalign_fault = w_split && !SPLIT_EN;
  assign w_timeout = (r_wait_cnt == CW'(MAX_WAIT - 1));

  // Buffer value including the word arriving this cycle, so the response
  // data can be registered on the same edge that leaves the WAIT state.
  logic [63:0] w_buf_next;
  always_comb begin
    w_buf_next = r_buf;
    if (r_state == S_WAIT0 && i_mem_rvalid) w_buf_next[31:0]  = i_mem_rdata;
    if (r_state == S_WAIT1 && i_mem_rvalid) w_buf_next[63:32] = i_mem_rdata;
  end

  logic [31:0] w_load_word, w_load_data;
  assign w_load_word = 32'(w_buf_next >> {r_addr[1:0], 3'b000});

  always_comb begin
    w_load_data = 32'h0;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_load_word[7]}}, w_load_word[7:0]};
      3'b001:  w_load_data = {{16{w_load_word[15]}}, w_load_word[15:0]};
      3'b010:  w_load_data = w_load_word;
      3'b100:  w_load_data = {24'h0, w_load_word[7:0]};
      3'b101:  w_load_data = {16'h0, w_load_word[15:0]};
      default: w_load_data = 32'h0;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  logic w_fault_next;
  always_comb begin
    w_state_next = r_state;
    w_fault_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (w_illegal || w_misalign_fault) begin
            w_state_next = S_RESP;
            w_fault_next = 1'b1;
          end else begin
            w_state_next = S_REQ0;
          end
        end
      end
      S_REQ0: begin
        if (i_mem_gnt) begin
          if (w_is_store) w_state_next = w_split ? S_REQ1 : S_RESP;
          else            w_state_next = S_WAIT0;
        end
      end
      S_WAIT0: begin
        if (i_mem_rvalid) begin
          w_state_next = w_split ? S_REQ1 : S_RESP;
        end else if (w_timeout) begin
          w_state_next = S_RESP;
          w_fault_next = 1'b1;
        end
      end
      S_REQ1: begin
        if (i_mem_gnt) w_state_next = w_is_store ? S_RESP : S_WAIT1;
      end
      S_WAIT1: begin
        if (i_mem_rvalid) begin
          w_state_next = S_RESP;
        end else if (w_timeout) begin
          w_state_next = S_RESP;
          w_fault_next = 1'b1;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (next values, registered below) ----------------
  logic            w_req_ready_next, w_resp_valid_next, w_resp_fault_next;
  logic [XLEN-1:0] w_resp_rdata_next;
  logic            w_mem_req_next, w_mem_we_next;
  logic [XLEN-1:0] w_mem_addr_next, w_mem_wdata_next;
  logic [3:0]      w_mem_wstrb_next;

  always_comb begin
    w_req_ready_next  = (w_state_next == S_IDLE);
    w_resp_valid_next = (w_state_next == S_RESP);
    w_resp_fault_next = (w_state_next == S_RESP) && w_fault_next;
    w_resp_rdata_next = 32'h0;
    if (w_state_next == S_RESP && !w_fault_next && !w_is_store)
      w_resp_rdata_next = w_load_data;
    w_mem_req_next   = (w_state_next == S_REQ0) || (w_state_next == S_REQ1);
    w_mem_we_next    = w_mem_req_next && w_is_store;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wstrb_next = 4'b0000;
    w_mem_wdata_next = 32'h0;
    if (w_state_next == S_REQ0) begin
      w_mem_addr_next = w_word0;
      if (w_is_store) begin
        w_mem_wstrb_next = w_s8[3:0];
        w_mem_wdata_next = w_d64[31:0];
      end
    end else if (w_state_next == S_REQ1) begin
      w_mem_addr_next = w_word1;
      if (w_is_store) begin
        w_mem_wstrb_next = w_s8[7:4];
        w_mem_wdata_next = w_d64[63:32];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 4'b0000;
      r_mem_wdata  <= '0;
    end else begin
      r_req_ready  <= w_req_ready_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_fault <= w_resp_fault_next;
      r_resp_rdata <= w_resp_rdata_next;
      r_mem_req    <= w_mem_req_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wstrb  <= w_mem_wstrb_next;
      r_mem_wdata  <= w_mem_wdata_next;
    end
  end

  // ---------------- Request latch, read buffer, watchdog ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_idle && i_req_valid) begin
        r_is_store <= i_req_is_store;
        r_funct3   <= i_req_funct3;
        r_addr     <= i_req_addr;
        r_wdata    <= i_req_wdata;
      end
      r_buf <= w_buf_next;
      // Counter restarts on every state change, so it measures time spent
      // in the current WAIT state only.
      if (w_state_next != r_state)
        r_wait_cnt <= '0;
      else if (r_state == S_WAIT0 || r_state == S_WAIT1)
        r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_fault = r_resp_fault;
  assign o_resp_rdata = r_resp_rdata;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wstrb  = r_mem_wstrb;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_initiator
//   Directed bench for lsu_mem_initiator. Each request is driven through a
//   cycle-stepped task that plays the memory side. The memory can delay the
//   grant and can return read data one cycle after each read grant. The task
//   logs granted transactions and the response. Expected values are
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_lsu_mem_initiator;

  localparam int MW = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.XLEN(32), .MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_is_store(req_is_store), .i_req_funct3(req_funct3),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_fault(resp_fault),
    .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Results of the last run
  logic [31:0] tx_addr[4];
  logic [31:0] tx_wdata[4];
  logic [3:0]  tx_strb[4];
  logic        tx_we[4];
  int          n_txn, lat, req_cycles;
  bit          unstable, got;
  logic [31:0] r_data;
  logic        r_fault;

  // Call at posedge+1 with the DUT idle. Returns at posedge+1 of the cycle
  // after the response (or after the cycle budget, leaving lat = -1).
  task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd0,
                     input logic [31:0] rd1, input int gnt_wait, input bit give_rv);
    int hold, nread;
    bit rv_pend, granted, prev_wait, s_req, s_we;
    logic [31:0] last_addr;
    n_txn = 0; lat = -1; got = 0; req_cycles = 0; unstable = 0;
    r_data = 32'h0; r_fault = 1'b0;
    hold = 0; nread = 0; rv_pend = 0; prev_wait = 0; last_addr = 32'h0;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int c = 0; c < 200; c++) begin
      mem_gnt    = mem_req && (hold >= gnt_wait);
      mem_rvalid = rv_pend && give_rv;
      mem_rdata  = rv_pend ? ((nread == 0) ? rd0 : rd1) : 32'h0;
      @(negedge clk);
      s_req   = mem_req;
      s_we    = mem_we;
      granted = mem_req && mem_gnt;
      if (mem_req) begin
        req_cycles++;
        if (prev_wait && mem_addr !== last_addr) unstable = 1;
        last_addr = mem_addr;
      end
      prev_wait = mem_req && !mem_gnt;
      if (granted) begin
        if (n_txn < 4) begin
          tx_addr[n_txn] = mem_addr; tx_wdata[n_txn] = mem_wdata;
          tx_strb[n_txn] = mem_wstrb; tx_we[n_txn] = mem_we;
        end
        n_txn++;
      end
      if (resp_valid && !got) begin
        got = 1; lat = c; r_data = resp_rdata; r_fault = resp_fault;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_rvalid) begin rv_pend = 0; nread++; end
      if (granted) begin
        hold = 0;
        if (!s_we) rv_pend = 1;
      end else if (s_req) begin
        hold++;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (got) break;
    end
    $display("txn st=%0b f3=%b addr=%h wdata=%h lat=%0d ntxn=%0d fault=%0b rdata=%h",
             st, f3, a, wd, lat, n_txn, r_fault, r_data);
  endtask

  bit any_resp;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 32'd1);
    chk("rst_mem_req", mem_req, 32'd0);
    chk("rst_resp_valid", resp_valid, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wstrb", mem_wstrb, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // SW aligned, minimum latency
    run(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 1);
    chk("sw_ntxn", n_txn, 32'd1);
    chk("sw_addr", tx_addr[0], 32'h100);
    chk("sw_we", tx_we[0], 32'd1);
    chk("sw_strb", tx_strb[0], 32'hF);
    chk("sw_wdata", tx_wdata[0], 32'hDEADBEEF);
    chk("sw_lat", lat, 32'd2);
    chk("sw_fault", r_fault, 32'd0);
    chk("sw_rdata", r_data, 32'h0);
    @(negedge clk);
    chk("pulse_one_cycle", resp_valid, 32'd0);
    chk("ready_back", req_ready, 32'd1);
    @(posedge clk); #1;

    // SB to top byte
    run(1, 3'b000, 32'h103, 32'h000000AA, 0, 0, 0, 1);
    chk("sb_addr", tx_addr[0], 32'h100);
    chk("sb_strb", tx_strb[0], 32'h8);
    chk("sb_wdata", tx_wdata[0], 32'hAA000000);

    // SH upper half: high wdata bits must not appear
    run(1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 0, 1);
    chk("sh_strb", tx_strb[0], 32'hC);
    chk("sh_wdata", tx_wdata[0], 32'hBEEF0000);

    // LB / LBU
    run(0, 3'b000, 32'h103, 0, 32'hAA000000, 0, 0, 1);
    chk("lb_data", r_data, 32'hFFFFFFAA);
    chk("lb_lat", lat, 32'd3);
    chk("lb_we", tx_we[0], 32'd0);
    chk("lb_strb", tx_strb[0], 32'h0);
    chk("lb_addr", tx_addr[0], 32'h100);
    run(0, 3'b100, 32'h103, 0, 32'hAA000000, 0, 0, 1);
    chk("lbu_data", r_data, 32'h000000AA);
    run(0, 3'b000, 32'h201, 0, 32'h00007F00, 0, 0, 1);
    chk("lb_pos_data", r_data, 32'h0000007F);

    // LH with grant held low 3 cycles, LHU
    run(0, 3'b001, 32'h102, 0, 32'h80010000, 0, 3, 1);
    chk("lh_data", r_data, 32'hFFFF8001);
    chk("lh_req_cycles", req_cycles, 32'd4);
    chk("lh_stable", unstable, 32'd0);
    chk("lh_lat", lat, 32'd6);
    run(0, 3'b101, 32'h102, 0, 32'h80010000, 0, 0, 1);
    chk("lhu_data", r_data, 32'h00008001);
    run(0, 3'b001, 32'h100, 0, 32'h0000FFFE, 0, 0, 1);
    chk("lh_lo_data", r_data, 32'hFFFFFFFE);
    run(0, 3'b010, 32'h200, 0, 32'h12345678, 0, 0, 1);
    chk("lw_data", r_data, 32'h12345678);

    // Misaligned word accesses
    run(0, 3'b010, 32'h1FE, 0, 32'h33445566, 32'h77881122, 0, 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lw_split_ntxn", n_txn, 32'd2);
    chk("lw_split_a0", tx_addr[0], 32'h1FC);
    chk("lw_split_a1", tx_addr[1], 32'h200);
    chk("lw_split_data", r_data, 32'h11223344);
    chk("lw_split_fault", r_fault, 32'd0);
    chk("lw_split_lat", lat, 32'd5);
`else
    chk("lw_mis_req", req_cycles, 32'd0);
    chk("lw_mis_fault", r_fault, 32'd1);
    chk("lw_mis_rdata", r_data, 32'h0);
    chk("lw_mis_lat", lat, 32'd1);
`endif
    run(1, 3'b010, 32'hFFFFFFFF, 32'h11223344, 0, 0, 0, 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("sw_wrap_ntxn", n_txn, 32'd2);
    chk("sw_wrap_a0", tx_addr[0], 32'hFFFFFFFC);
    chk("sw_wrap_s0", tx_strb[0], 32'h8);
    chk("sw_wrap_d0", tx_wdata[0], 32'h44000000);
    chk("sw_wrap_a1", tx_addr[1], 32'h00000000);
    chk("sw_wrap_s1", tx_strb[1], 32'h7);
    chk("sw_wrap_d1", tx_wdata[1], 32'h00112233);
    chk("sw_wrap_lat", lat, 32'd3);
`else
    chk("sw_mis_req", req_cycles, 32'd0);
    chk("sw_mis_fault", r_fault, 32'd1);
`endif

    // Illegal funct3
    run(0, 3'b011, 32'h100, 0, 32'h12345678, 0, 0, 1);
    chk("f011_fault", r_fault, 32'd1);
    chk("f011_req", req_cycles, 32'd0);
    chk("f011_rdata", r_data, 32'h0);
    run(1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 1);
    chk("sbu_fault", r_fault, 32'd1);
    chk("sbu_req", req_cycles, 32'd0);

    // Watchdog: read data never returns
    run(0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 0, 0, 0);
    chk("wd_fault", r_fault, 32'd1);
    chk("wd_rdata", r_data, 32'h0);
    chk("wd_lat", lat, MW + 2);
    // Stale rvalid in IDLE must be ignored
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    any_resp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || mem_req) any_resp = 1;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    chk("wd_stale_ignored", any_resp, 32'd0);

    // Reset during WAIT0
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    @(posedge clk); #1;           // REQ0
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;           // WAIT0
    mem_gnt = 1'b0;
    reset = 1'b1; #1;
    chk("rst_wait_mem_req", mem_req, 32'd0);
    chk("rst_wait_ready", req_ready, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    any_resp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || mem_req) any_resp = 1;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    chk("rst_wait_no_resp", any_resp, 32'd0);

    // Reset during REQ0 with grant withheld: mem_req drops without a clock
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h500;
    req_wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req0_mem_req", mem_req, 32'd1);
    reset = 1'b1; #1;
    chk("rst_req0_mem_req", mem_req, 32'd0);
    chk("rst_req0_we", mem_we, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Normal operation after reset
    run(0, 3'b010, 32'h600, 0, 32'hA5A5A5A5, 0, 0, 1);
    chk("post_rst_data", r_data, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
